seg_score_decoder: RTL
======================

# seg_score_decoder

Recovers the numeric snake score from the two-digit, active-low seven-segment pattern driven to the score display. It sits on the display bus as a readback monitor for self-check and score logging. Candidate patterns are qualified for stability before decoding. Legal values are emitted through a valid/ready handshake in both binary and score-code format (value × 4); illegal patterns are counted.

## Interface
- STABLE_CYCLES, 4: consecutive identical sampled patterns required before decode (≥1)
- ERR_W, 8: width of saturating error counter
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- seg_in  in  14  [13:7] tens digit, [6:0] units digit; active-low segments, gfedcba order
- seg_valid  in  1  sample strobe; seg_in considered only when high
- out_ready  in  1  consumer accepts output
- out_valid  out  1  decoded score available
- score  out  5  decoded value 0..31
- score_code  out  7  {score, 2'b00}, matching the display driver's input format
- err  out  1  one-cycle pulse on illegal qualified pattern
- err_count  out  ERR_W  illegal patterns seen, saturates at all-ones

## Operation
- Digit patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Legal: tens ∈ {0,1,2,3}, units ∈ 0..9, tens×10+units ≤ 31. Any other pattern is illegal.
- FSM states: IDLE, QUAL, HOLD.
- IDLE: on seg_valid, load cand ← seg_in and cnt ← 1, then go to QUAL. If STABLE_CYCLES=1, decode immediately instead.
- QUAL, seg_valid with seg_in = cand: cnt++. When cnt reaches STABLE_CYCLES, decode cand.
- QUAL, seg_valid with seg_in ≠ cand: cand ← seg_in, cnt ← 1, stay in QUAL.
- Cycles without seg_valid: no state change.
- Decode outcomes:
  - Illegal: err pulse, err_count increment (saturating), go to IDLE.
  - Legal and equal to last emitted value (last_ok=1): silently go to IDLE (change suppression).
  - Otherwise: register score and score_code, go to HOLD.
- HOLD: out_valid=1, outputs frozen, seg_in ignored. On out_valid & out_ready: last ← score, last_ok ← 1, go to IDLE.

## Timing
- Reset values: out_valid=0, score=0, score_code=0, err=0, err_count=0, last_ok=0, state IDLE.
- Latency with continuous seg_valid: out_valid rises on the clock edge that samples the STABLE_CYCLES-th matching pattern. err pulses on the same edge in the illegal case.
- Handshake: out_valid never drops without out_ready. score and score_code are stable while out_valid=1.
- Sampling resumes the cycle after acceptance. A seg_valid on the accept cycle itself is ignored.
- Saturation: err_count at all-ones stays at all-ones; err still pulses.
- Reset asserted mid-QUAL or mid-HOLD clears everything asynchronously. The pending value is lost, and last_ok=0, so the next legal value is always emitted.

## Structure
- Shared include seg_patterns.vh holds SEG_0..SEG_9 localparams (7-bit, active low). It is used by both the display encoder and this block.
- Sub-module seg_digit_decode: combinational, pattern[6:0] → digit[3:0] + legal. Instantiated twice, once for tens and once for units.
- Top level holds the FSM, candidate register, stability counter, last-value register, and error counter.

## Test plan
- Reset: assert rst_n=0 mid-run → all outputs 0 immediately, FSM in IDLE.
- Basic decode: seg_in=11110010110000 (13) for 4 valid cycles, out_ready=1 → out_valid for 1 cycle, score=13, score_code=0110100.
- Backpressure: 01100001111001 (31) qualified, out_ready=0 for 5 cycles → out_valid and score=31 held; accepted on the cycle out_ready=1.
- Glitch: 3 samples of 22 (01001000100100), then 5 samples of 23 (01001000110000) → single emission score=23; 22 never emitted.
- Illegal: 01100000010010 ("35") held 4 samples → err pulse, err_count=1, no out_valid. Repeat 300 times → err_count=255.
- Suppression: 13 emitted and accepted, then 13 held again → no out_valid. A subsequent reset and 13 again → emitted.

Source files
------------

// File: rtl/seg_score_decoder_pkg.sv
// Shared types and constants for the seven-segment score readback decoder.
package seg_score_decoder_pkg;

  `include "seg_patterns.vh"

  // Largest score the display can legally show.
  localparam int unsigned ScoreMax = 31;

  typedef enum logic [1:0] {
    StIdle,
    StQual,
    StHold
  } state_e;

endpackage

// File: rtl/seg_digit_decode.sv
// Combinational decode of one active-low seven-segment digit.
//   pattern_i : 7-bit active-low pattern, gfedcba order
//   digit_o   : decoded digit 0..9 (0 when illegal)
//   legal_o   : pattern is one of the ten digit glyphs
module seg_digit_decode
  import seg_score_decoder_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] digit_o,
  output logic       legal_o
);

  always_comb begin
    digit_o = 4'd0;
    legal_o = 1'b1;
    case (pattern_i)
      SEG_0:   digit_o = 4'd0;
      SEG_1:   digit_o = 4'd1;
      SEG_2:   digit_o = 4'd2;
      SEG_3:   digit_o = 4'd3;
      SEG_4:   digit_o = 4'd4;
      SEG_5:   digit_o = 4'd5;
      SEG_6:   digit_o = 4'd6;
      SEG_7:   digit_o = 4'd7;
      SEG_8:   digit_o = 4'd8;
      SEG_9:   digit_o = 4'd9;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_patterns.vh
// Seven-segment digit patterns shared by the score display encoder and the readback decoder.
// Active-low segments in gfedcba order: a 0 bit lights the segment.
`ifndef SEG_PATTERNS_VH
`define SEG_PATTERNS_VH
localparam logic [6:0] SEG_0 = 7'b1000000;
localparam logic [6:0] SEG_1 = 7'b1111001;
localparam logic [6:0] SEG_2 = 7'b0100100;
localparam logic [6:0] SEG_3 = 7'b0110000;
localparam logic [6:0] SEG_4 = 7'b0011001;
localparam logic [6:0] SEG_5 = 7'b0010010;
localparam logic [6:0] SEG_6 = 7'b0000010;
localparam logic [6:0] SEG_7 = 7'b1111000;
localparam logic [6:0] SEG_8 = 7'b0000000;
localparam logic [6:0] SEG_9 = 7'b0010000;
`endif

// File: rtl/seg_score_decoder.sv
// Readback monitor recovering the two-digit snake score from the display bus.
// A sampled pattern must repeat StableCycles times before it is decoded; legal
// values are offered on a valid/ready port, illegal ones pulse err and are counted.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   seg_in_i      : [13:7] tens, [6:0] units, active-low gfedcba
//   seg_valid_i   : sample strobe
//   out_ready_i   : consumer accepts score
//   out_valid_o   : decoded score held for the consumer
//   score_o       : decoded value 0..31
//   score_code_o  : score * 4, display driver input format
//   err_o         : one-cycle pulse per illegal qualified pattern
//   err_count_o   : saturating count of illegal patterns
module seg_score_decoder
  import seg_score_decoder_pkg::*;
#(
  parameter int unsigned StableCycles = 4,
  parameter int unsigned ErrW         = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [13:0]     seg_in_i,
  input  logic            seg_valid_i,
  input  logic            out_ready_i,
  output logic            out_valid_o,
  output logic [4:0]      score_o,
  output logic [6:0]      score_code_o,
  output logic            err_o,
  output logic [ErrW-1:0] err_count_o
);

  localparam int unsigned CntW = (StableCycles > 1) ? $clog2(StableCycles + 1) : 1;

  state_e            state_q, state_d;
  logic [13:0]       cand_q, cand_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   cnt_inc;
  logic [4:0]        score_q, score_d;
  logic [4:0]        last_q, last_d;
  logic              last_ok_q, last_ok_d;
  logic              err_q, err_d;
  logic [ErrW-1:0]   err_cnt_q, err_cnt_d;

  logic [3:0]        tens_digit, units_digit;
  logic              tens_legal, units_legal;
  logic [6:0]        value;
  logic              value_legal;
  logic              decode_now;

  // Whenever a decode fires, the pattern being decoded equals the current
  // sample, so the digit decoders look straight at the bus.
  seg_digit_decode u_tens (
    .pattern_i (seg_in_i[13:7]),
    .digit_o   (tens_digit),
    .legal_o   (tens_legal)
  );

  seg_digit_decode u_units (
    .pattern_i (seg_in_i[6:0]),
    .digit_o   (units_digit),
    .legal_o   (units_legal)
  );

  assign value       = {3'b000, tens_digit} * 7'd10 + {3'b000, units_digit};
  // value <= 31 also bounds the tens digit to 0..3.
  assign value_legal = tens_legal && units_legal && (value <= 7'(ScoreMax));
  assign cnt_inc     = cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    score_d    = score_q;
    last_d     = last_q;
    last_ok_d  = last_ok_q;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    decode_now = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (seg_valid_i) begin
          if (StableCycles == 1) begin
            decode_now = 1'b1;
          end else begin
            cand_d  = seg_in_i;
            cnt_d   = CntW'(1);
            state_d = StQual;
          end
        end
      end
      StQual: begin
        if (seg_valid_i) begin
          if (seg_in_i == cand_q) begin
            if (cnt_inc == CntW'(StableCycles)) begin
              decode_now = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cand_d = seg_in_i;
            cnt_d  = CntW'(1);
          end
        end
      end
      StHold: begin
        // Bus is ignored here; sampling restarts the cycle after acceptance.
        if (out_ready_i) begin
          last_d    = score_q;
          last_ok_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (decode_now) begin
      if (!value_legal) begin
        err_d   = 1'b1;
        state_d = StIdle;
        if (err_cnt_q != '1) begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
      end else if (last_ok_q && (value[4:0] == last_q)) begin
        // Same score as last delivered: nothing new to report.
        state_d = StIdle;
      end else begin
        score_d = value[4:0];
        state_d = StHold;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cand_q    <= '0;
      cnt_q     <= '0;
      score_q   <= '0;
      last_q    <= '0;
      last_ok_q <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      score_q   <= score_d;
      last_q    <= last_d;
      last_ok_q <= last_ok_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_valid_o  = (state_q == StHold);
  assign score_o      = score_q;
  assign score_code_o = {score_q, 2'b00};
  assign err_o        = err_q;
  assign err_count_o  = err_cnt_q;

endmodule
